decode_stage: RTL and testbench

Registered, parametrised instruction-decode pipeline stage for the simple CPU. It is the successor of the combinational field decoder.
- Accepts raw instruction words over a valid/ready handshake.
- Splits each word into prefix, opcode, rs, rd and immediate fields.
- Flags HLT and illegal opcodes.
- Extends the immediate to data width.
- Presents results through a 2-entry skid buffer to execute.
- Provides sticky halt, resume and flush control for the core sequencer.

---
 rtl/cpu_isa_pkg.sv | 41 ++++
 rtl/decode_skid_buf.sv | 89 ++++++++
 rtl/decode_stage.sv | 161 ++++++++++++++++
 tb/tb_decode_stage.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_isa_pkg.sv
// cpu_isa_pkg
//   Shared ISA definitions for the simple CPU: instruction field widths,
//   opcode values, the decode-stage halt sequencer states and the decoded
//   entry carried from decode to execute.
package cpu_isa_pkg;

    localparam int PFIX_W  = 2;
    localparam int OPC_W   = 6;
    localparam int REG_W   = 4;
    localparam int IMM_W   = 16;
    localparam int DATA_W  = 32;
    localparam int INSTR_W = PFIX_W + OPC_W + 2 * REG_W + IMM_W;

    localparam logic [OPC_W-1:0] NOP     = 6'b000000;
    localparam logic [OPC_W-1:0] ADD     = 6'b000001;
    localparam logic [OPC_W-1:0] SUB     = 6'b000010;
    localparam logic [OPC_W-1:0] LDI     = 6'b000011;
    localparam logic [OPC_W-1:0] LD      = 6'b000100;
    localparam logic [OPC_W-1:0] ST      = 6'b000101;
    localparam logic [OPC_W-1:0] JMP     = 6'b001000;
    localparam logic [OPC_W-1:0] HLT     = 6'b001011;
    localparam logic [OPC_W-1:0] OPC_MAX = HLT;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_HLT_PEND = 2'd1,
        ST_HALTED   = 2'd2
    } halt_state_t;

    typedef struct packed {
        logic [PFIX_W-1:0] pfix;
        logic [OPC_W-1:0]  opcode;
        logic [REG_W-1:0]  rs;
        logic [REG_W-1:0]  rd;
        logic [IMM_W-1:0]  imm;
        logic [DATA_W-1:0] imm_ext;
        logic              halt;
        logic              illegal;
    } decoded_t;

endpackage

// File: rtl/decode_skid_buf.sv
// decode_skid_buf
//   Two-entry valid/ready skid buffer, generic over payload width.
//   Slot 0 is the output register, slot 1 the skid register.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   i_flush        synchronous discard of both slots (no transfers that cycle)
//   i_valid/o_ready/i_data   upstream handshake (o_ready = skid empty)
//   o_valid/i_ready/o_data   downstream handshake
//   o_skid_nxt     skid occupancy after the coming edge
module decode_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_flush,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data,
    output logic         o_skid_nxt
);

    logic         r_out_valid;
    logic         r_skid_valid;
    logic [W-1:0] r_out_data;
    logic [W-1:0] r_skid_data;

    logic w_push;
    logic w_pop;
    logic w_out_valid_nxt;
    logic w_skid_valid_nxt;
    logic w_load_out_in;
    logic w_load_out_skid;
    logic w_load_skid;

    always_comb begin
        w_push           = i_valid && !r_skid_valid && !i_flush;
        w_pop            = r_out_valid && i_ready && !i_flush;
        w_out_valid_nxt  = r_out_valid;
        w_skid_valid_nxt = r_skid_valid;
        w_load_out_in    = 1'b0;
        w_load_out_skid  = 1'b0;
        w_load_skid      = 1'b0;
        if (i_flush) begin
            w_out_valid_nxt  = 1'b0;
            w_skid_valid_nxt = 1'b0;
        end else if (w_pop && r_skid_valid) begin
            // Skid full means no push can happen this cycle.
            w_load_out_skid  = 1'b1;
            w_skid_valid_nxt = 1'b0;
        end else if (w_push && (w_pop || !r_out_valid)) begin
            w_load_out_in   = 1'b1;
            w_out_valid_nxt = 1'b1;
        end else if (w_push) begin
            w_load_skid      = 1'b1;
            w_skid_valid_nxt = 1'b1;
        end else if (w_pop) begin
            w_out_valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
            r_out_data   <= '0;
            r_skid_data  <= '0;
        end else begin
            r_out_valid  <= w_out_valid_nxt;
            r_skid_valid <= w_skid_valid_nxt;
            if (w_load_out_in) begin
                r_out_data <= i_data;
            end else if (w_load_out_skid) begin
                r_out_data <= r_skid_data;
            end
            if (w_load_skid) begin
                r_skid_data <= i_data;
            end
        end
    end

    assign o_ready    = !r_skid_valid;
    assign o_valid    = r_out_valid;
    assign o_data     = r_out_data;
    assign o_skid_nxt = w_skid_valid_nxt;

endmodule

// File: rtl/decode_stage.sv
// decode_stage
//   Registered instruction-decode stage: splits each accepted word into
//   prefix/opcode/rs/rd/imm, extends the immediate, flags HLT and illegal
//   opcodes, and hands entries to execute through a 2-entry skid buffer.
//   A halt sequencer stops intake after HLT until resume.
// Ports:
//   clk, rst                       clock, asynchronous active-high reset
//   in_valid/in_ready/instr        instruction input handshake
//   out_valid/out_ready            decoded-entry output handshake
//   pfix, opcode, rs, rd, imm      decoded fields of the head entry
//   imm_ext                        imm sign-extended when pfix[0], else zero-extended
//   out_halt, out_illegal          head entry is HLT / has an illegal opcode
//   halted                         sticky: HLT entry consumed by execute
//   flush, resume                  sequencer control pulses
module decode_stage
    import cpu_isa_pkg::*;
#(
    parameter int INSTR_W = cpu_isa_pkg::INSTR_W,
    parameter int PFIX_W  = cpu_isa_pkg::PFIX_W,
    parameter int OPC_W   = cpu_isa_pkg::OPC_W,
    parameter int REG_W   = cpu_isa_pkg::REG_W,
    parameter int IMM_W   = cpu_isa_pkg::IMM_W,
    parameter int DATA_W  = cpu_isa_pkg::DATA_W,
    parameter logic [OPC_W-1:0] HLT_OPC = cpu_isa_pkg::HLT,
    parameter logic [OPC_W-1:0] OPC_MAX = cpu_isa_pkg::OPC_MAX
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] instr,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [PFIX_W-1:0]  pfix,
    output logic [OPC_W-1:0]   opcode,
    output logic [REG_W-1:0]   rs,
    output logic [REG_W-1:0]   rd,
    output logic [IMM_W-1:0]   imm,
    output logic [DATA_W-1:0]  imm_ext,
    output logic               out_halt,
    output logic               out_illegal,
    output logic               halted,
    input  logic               flush,
    input  logic               resume
);

    if (INSTR_W != PFIX_W + OPC_W + 2 * REG_W + IMM_W) begin : g_err_instr_w
        $error("decode_stage: INSTR_W must equal PFIX_W+OPC_W+2*REG_W+IMM_W");
    end
    if (DATA_W < IMM_W) begin : g_err_data_w
        $error("decode_stage: DATA_W must be >= IMM_W");
    end
    // The entry type is shared with execute, so field widths are tied to it.
    if (PFIX_W != cpu_isa_pkg::PFIX_W || OPC_W != cpu_isa_pkg::OPC_W ||
        REG_W != cpu_isa_pkg::REG_W || IMM_W != cpu_isa_pkg::IMM_W ||
        DATA_W != cpu_isa_pkg::DATA_W) begin : g_err_pkg_w
        $error("decode_stage: field widths must match cpu_isa_pkg::decoded_t");
    end

    decoded_t    w_dec;
    decoded_t    w_head;
    halt_state_t r_state;
    logic        r_in_ready;
    logic        r_halted;
    logic        w_accept;
    logic        w_pop;
    logic        w_skid_nxt;
    logic        w_buf_ready;
    logic        w_buf_valid;

    always_comb begin
        w_dec         = '0;
        w_dec.pfix    = instr[INSTR_W-1 -: PFIX_W];
        w_dec.opcode  = instr[INSTR_W-PFIX_W-1 -: OPC_W];
        w_dec.rs      = instr[INSTR_W-PFIX_W-OPC_W-1 -: REG_W];
        w_dec.rd      = instr[IMM_W+REG_W-1 -: REG_W];
        w_dec.imm     = instr[IMM_W-1:0];
        w_dec.imm_ext = w_dec.pfix[0] ? DATA_W'(signed'(w_dec.imm)) : DATA_W'(w_dec.imm);
        w_dec.illegal = (w_dec.opcode > OPC_MAX);
        w_dec.halt    = (w_dec.opcode == HLT_OPC) && !w_dec.illegal;
    end

    assign w_accept = in_valid && r_in_ready && w_buf_ready && !flush;
    assign w_pop    = w_buf_valid && out_ready && !flush;

    decode_skid_buf #(
        .W ($bits(decoded_t))
    ) u_skid (
        .clk        (clk),
        .rst        (rst),
        .i_flush    (flush),
        .i_valid    (w_accept),
        .o_ready    (w_buf_ready),
        .i_data     (w_dec),
        .o_valid    (w_buf_valid),
        .i_ready    (out_ready),
        .o_data     (w_head),
        .o_skid_nxt (w_skid_nxt)
    );

    // in_ready is registered from next-cycle skid occupancy and state, so it
    // never depends combinationally on out_ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_halted   <= 1'b0;
            r_in_ready <= 1'b0;
        end else if (flush && !(r_state == ST_HALTED && !resume)) begin
            r_state    <= ST_RUN;
            r_halted   <= 1'b0;
            r_in_ready <= 1'b1;
        end else if (flush) begin
            r_in_ready <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (w_accept && w_dec.halt) begin
                        r_state    <= ST_HLT_PEND;
                        r_in_ready <= 1'b0;
                    end else begin
                        r_in_ready <= !w_skid_nxt;
                    end
                end
                ST_HLT_PEND: begin
                    r_in_ready <= 1'b0;
                    if (w_pop && w_head.halt) begin
                        r_state  <= ST_HALTED;
                        r_halted <= 1'b1;
                    end
                end
                ST_HALTED: begin
                    if (resume) begin
                        r_state    <= ST_RUN;
                        r_halted   <= 1'b0;
                        r_in_ready <= !w_skid_nxt;
                    end else begin
                        r_in_ready <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ST_RUN;
                    r_halted   <= 1'b0;
                    r_in_ready <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready    = r_in_ready;
    assign halted      = r_halted;
    assign out_valid   = w_buf_valid;
    assign pfix        = w_head.pfix;
    assign opcode      = w_head.opcode;
    assign rs          = w_head.rs;
    assign rd          = w_head.rd;
    assign imm         = w_head.imm;
    assign imm_ext     = w_head.imm_ext;
    assign out_halt    = w_head.halt;
    assign out_illegal = w_head.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage
//   Self-checking bench for decode_stage: directed scenarios followed by
//   randomized traffic, all compared against a queue-based reference model.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic        out_valid;
    logic        out_ready;
    logic [1:0]  pfix;
    logic [5:0]  opcode;
    logic [3:0]  rs;
    logic [3:0]  rd;
    logic [15:0] imm;
    logic [31:0] imm_ext;
    logic        out_halt;
    logic        out_illegal;
    logic        halted;
    logic        flush;
    logic        resume;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instr       (instr),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .pfix        (pfix),
        .opcode      (opcode),
        .rs          (rs),
        .rd          (rd),
        .imm         (imm),
        .imm_ext     (imm_ext),
        .out_halt    (out_halt),
        .out_illegal (out_illegal),
        .halted      (halted),
        .flush       (flush),
        .resume      (resume)
    );

    // Reference model: a queue of expected entries plus a sequencer mode
    // (0 = running, 1 = halt pending, 2 = halted).
    typedef struct {
        logic [31:0] word;
        logic [31:0] ext;
        logic        hlt;
        logic        ill;
    } exp_t;

    exp_t        q[$];
    int unsigned m_mode = 0;
    bit          m_live = 1'b0;
    bit          last_acc = 1'b0;
    int unsigned n_checks = 0;
    int unsigned n_fail = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic exp_t ref_decode(input logic [31:0] w);
        exp_t        e;
        int unsigned opc;
        int unsigned p;
        int unsigned lo;
        opc    = (w >> 24) & 32'h3F;
        p      = w >> 30;
        lo     = w & 32'hFFFF;
        e.word = w;
        e.ext  = ((p % 2) == 1 && lo >= 32768) ? (lo + 32'hFFFF0000) : lo;
        e.ill  = (opc > 11);
        e.hlt  = (opc == 11);
        return e;
    endfunction

    function automatic bit exp_rdy();
        return m_live && (q.size() < 2) && (m_mode == 0);
    endfunction

    task automatic compare_outputs();
        check_eq("in_ready", in_ready, exp_rdy());
        check_eq("out_valid", out_valid, q.size() > 0);
        check_eq("halted", halted, m_mode == 2);
        if (q.size() > 0) begin
            check_eq("fields", {pfix, opcode, rs, rd, imm}, q[0].word);
            check_eq("imm_ext", imm_ext, q[0].ext);
            check_eq("flags", {out_halt, out_illegal}, {q[0].hlt, q[0].ill});
        end
    endtask

    // One clock: update the model at the rising edge, compare at the falling edge.
    task automatic cyc();
        bit          acc;
        bit          pop;
        int unsigned s0;
        @(posedge clk);
        s0  = m_mode;
        acc = in_valid && exp_rdy() && !flush && !rst;
        pop = (q.size() > 0) && out_ready && !flush;
        if (rst) begin
            q.delete();
            m_mode = 0;
            m_live = 1'b0;
            acc    = 1'b0;
        end else begin
            if (flush) begin
                q.delete();
                if (m_mode == 1) m_mode = 0;
            end else begin
                if (pop) begin
                    if (q[0].hlt) m_mode = 2;
                    void'(q.pop_front());
                end
                if (acc) begin
                    q.push_back(ref_decode(instr));
                    if (q[q.size()-1].hlt) m_mode = 1;
                end
            end
            if (resume && s0 == 2) m_mode = 0;
            m_live = 1'b1;
        end
        last_acc = acc;
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic async_reset();
        #2;
        rst = 1'b1;
        #1;
        check_eq("ar_out_valid", out_valid, 0);
        check_eq("ar_in_ready", in_ready, 0);
        check_eq("ar_halted", halted, 0);
        q.delete();
        m_mode = 0;
        m_live = 1'b0;
        cyc();
        @(negedge clk);
        rst = 1'b0;
        cyc();
        cyc();
    endtask

    logic [15:0] got[$];
    bit          seen_hlt;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        instr     = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        resume    = 1'b0;

        // Reset values
        cyc();
        cyc();
        check_eq("rst_fields", {pfix, opcode, rs, rd, imm}, 32'h0);
        check_eq("rst_imm_ext", imm_ext, 32'h0);
        check_eq("rst_flags", {out_halt, out_illegal}, 2'b00);
        rst = 1'b0;
        cyc();
        cyc();

        // Field split, sign- and zero-extension
        out_ready = 1'b1;
        in_valid  = 1'b1;
        instr     = 32'h4312ABCD;
        cyc();
        check_eq("fs_valid", out_valid, 1);
        check_eq("fs_pfix", pfix, 2'b01);
        check_eq("fs_opcode", opcode, 6'h03);
        check_eq("fs_rs_rd", {rs, rd}, 8'h12);
        check_eq("fs_imm", imm, 16'hABCD);
        check_eq("fs_imm_ext_s", imm_ext, 32'hFFFFABCD);
        check_eq("fs_flags", {out_halt, out_illegal}, 2'b00);
        instr = 32'h0312ABCD;
        cyc();
        check_eq("fs_imm_ext_z", imm_ext, 32'h0000ABCD);
        in_valid = 1'b0;
        cyc();

        // Backpressure fills both slots, then drains in order
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 32'h01000001;
        cyc();
        instr = 32'h01000002;
        cyc();
        check_eq("bp_in_ready", in_ready, 0);
        instr = 32'h01000003;
        cyc();
        cyc();
        out_ready = 1'b1;
        got.delete();
        for (int k = 0; k < 10 && got.size() < 3; k++) begin
            if (out_valid) got.push_back(imm);
            cyc();
            if (last_acc) in_valid = 1'b0;
        end
        check_eq("bp_count", got.size(), 3);
        for (int k = 0; k < got.size(); k++) check_eq("bp_order", got[k], k + 1);

        // Halt, blocked intake, resume
        in_valid = 1'b1;
        instr    = 32'h01000005;
        cyc();
        instr = 32'h0B000000;
        cyc();
        check_eq("hlt_in_ready", in_ready, 0);
        instr    = 32'h01000007;
        seen_hlt = 1'b0;
        for (int k = 0; k < 10 && !halted; k++) begin
            if (out_valid && out_halt) seen_hlt = 1'b1;
            cyc();
        end
        check_eq("hlt_seen", seen_hlt, 1);
        check_eq("hlt_halted", halted, 1);
        check_eq("hlt_blocked", in_ready, 0);
        resume = 1'b1;
        cyc();
        resume = 1'b0;
        check_eq("res_halted", halted, 0);
        check_eq("res_in_ready", in_ready, 1);
        cyc();
        check_eq("res_accept", {out_valid, imm}, {1'b1, 16'h0007});
        in_valid = 1'b0;
        cyc();

        // Illegal opcode
        in_valid = 1'b1;
        instr    = 32'h0C000000;
        cyc();
        in_valid = 1'b0;
        check_eq("ill_flags", {out_valid, out_halt, out_illegal}, 3'b101);
        cyc();
        check_eq("ill_no_halt", halted, 0);

        // Flush at TWO with halt pending
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 32'h01000001;
        cyc();
        instr = 32'h0B000000;
        cyc();
        check_eq("fl_pre_ready", in_ready, 0);
        instr = 32'h01000009;
        flush = 1'b1;
        cyc();
        flush = 1'b0;
        check_eq("fl_out_valid", out_valid, 0);
        check_eq("fl_in_ready", in_ready, 1);
        check_eq("fl_halted", halted, 0);
        cyc();
        check_eq("fl_accept", {out_valid, imm}, {1'b1, 16'h0009});
        in_valid  = 1'b0;
        out_ready = 1'b1;
        cyc();

        // Asynchronous reset mid-stream
        out_ready = 1'b0;
        in_valid  = 1'b1;
        instr     = 32'h01000003;
        cyc();
        in_valid = 1'b0;
        check_eq("ar_pre_valid", out_valid, 1);
        async_reset();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if (!in_valid || last_acc) begin
                logic [31:0] w;
                w        = $urandom;
                w[29:24] = 6'($urandom_range(0, 15));
                instr    = w;
                in_valid = ($urandom_range(0, 3) != 0);
            end
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            resume    = ($urandom_range(0, 7) == 0);
            cyc();
            if (i == 1500) async_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
